// File: rtl/axi_pkg.sv
// +----------------------------------------------------------------------------+
// | Package : axi_pkg                                                          |
// | Brief   : AXI4 encodings and 64-bit address/data channel structs shared    |
// |           by the IOMMU memory-side masters and their interface wrapper.    |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package axi_pkg;

  localparam int unsigned ID_W   = 4;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              lock;
    logic [3:0]        cache;
    logic [2:0]        prot;
    logic [3:0]        qos;
  } aw_chan_t;

  typedef aw_chan_t ar_chan_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
  } w_chan_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_chan_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

endpackage

`default_nettype wire

// File: rtl/rv_iommu_pkg.sv
// +----------------------------------------------------------------------------+
// | Package : rv_iommu_pkg                                                     |
// | Brief   : Per-requestor AXI IDs used by the data-structures interface      |
// |           wrapper to route W/B traffic back to its masters.                |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package rv_iommu_pkg;

  localparam logic [axi_pkg::ID_W-1:0] AXI_ID_CQ     = 4'd0;
  localparam logic [axi_pkg::ID_W-1:0] AXI_ID_FQ     = 4'd1;
  localparam logic [axi_pkg::ID_W-1:0] AXI_ID_MSI_IG = 4'd2;
  localparam logic [axi_pkg::ID_W-1:0] AXI_ID_MRIF   = 4'd3;

endpackage

`default_nettype wire

// File: rtl/rv_iommu_rec_wr.sv
// +----------------------------------------------------------------------------+
// | Module  : rv_iommu_rec_wr                                                  |
// | Brief   : Single-outstanding AXI write master committing one fixed-size    |
// |           record as a single INCR burst (AW, then W beats, then B).        |
// |           Optional B-wait timeout: define RV_IOMMU_REC_WR_TIMEOUT_EN.      |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rv_iommu_rec_wr
  import axi_pkg::*;
  import rv_iommu_pkg::*;
#(
  parameter type               axi_req_t      = axi_pkg::req_t,
  parameter type               axi_rsp_t      = axi_pkg::resp_t,
  parameter logic [ID_W-1:0]   AXI_ID         = AXI_ID_CQ,
  parameter int unsigned       N_BEATS        = 4,
  parameter int unsigned       TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [63:0]            req_addr_i,
  input  logic [64*N_BEATS-1:0]  req_data_i,
  output logic                   done_o,
  output logic                   error_o,
  output logic                   timeout_o,
  output axi_req_t               mem_req_o,
  input  axi_rsp_t               mem_resp_i
);

  localparam int unsigned       CNT_W     = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(N_BEATS - 1);

  if (N_BEATS < 1 || N_BEATS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("rv_iommu_rec_wr: N_BEATS must be 1..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
`ifdef RV_IOMMU_REC_WR_TIMEOUT_EN
    ST_DRAIN,
`endif
    ST_B
  } state_e;

  state_e                 state;
  logic                   req_ready;
  logic                   aw_valid;
  logic                   w_valid;
  logic                   b_ready;
  logic                   done;
  logic                   error;
  logic [63:0]            addr;
  logic [64*N_BEATS-1:0]  data;
  logic [CNT_W-1:0]       beat_cnt;

`ifdef RV_IOMMU_REC_WR_TIMEOUT_EN
  localparam int unsigned      TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt;
  logic            timeout;
  assign timeout_o = timeout;
`else
  assign timeout_o = 1'b0;
`endif

  // Transaction sequencer: one record at a time, every handshake-facing output registered
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      aw_valid  <= 1'b0;
      w_valid   <= 1'b0;
      b_ready   <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      addr      <= '0;
      data      <= '0;
      beat_cnt  <= '0;
`ifdef RV_IOMMU_REC_WR_TIMEOUT_EN
      to_cnt    <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
`ifdef RV_IOMMU_REC_WR_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            // Records are 8-byte aligned; low address bits are ignored
            addr      <= {req_addr_i[63:3], 3'b000};
            data      <= req_data_i;
            req_ready <= 1'b0;
            aw_valid  <= 1'b1;
            state     <= ST_AW;
          end
        end
        ST_AW: begin
          if (mem_resp_i.aw_ready) begin
            aw_valid <= 1'b0;
            w_valid  <= 1'b1;
            beat_cnt <= '0;
            state    <= ST_W;
          end
        end
        ST_W: begin
          if (mem_resp_i.w_ready) begin
            if (beat_cnt == LAST_BEAT) begin
              w_valid <= 1'b0;
              b_ready <= 1'b1;
              state   <= ST_B;
`ifdef RV_IOMMU_REC_WR_TIMEOUT_EN
              to_cnt  <= '0;
`endif
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        ST_B: begin
          // A B landing on the limit cycle wins over the timeout
          if (mem_resp_i.b_valid) begin
            b_ready   <= 1'b0;
            done      <= 1'b1;
            error     <= (mem_resp_i.b.resp != RESP_OKAY);
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
`ifdef RV_IOMMU_REC_WR_TIMEOUT_EN
          else if (to_cnt == TO_LIMIT) begin
            done    <= 1'b1;
            error   <= 1'b1;
            timeout <= 1'b1;
            state   <= ST_DRAIN;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
`ifdef RV_IOMMU_REC_WR_TIMEOUT_EN
        ST_DRAIN: begin
          // Swallow the late B silently; completion was already reported
          if (mem_resp_i.b_valid) begin
            b_ready   <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  // AXI request assembly: fixed burst shape, beat data selected by the beat counter
  always_comb begin
    mem_req_o          = '0;
    mem_req_o.aw_valid = aw_valid;
    mem_req_o.aw.id    = AXI_ID;
    mem_req_o.aw.addr  = addr;
    mem_req_o.aw.len   = 8'(N_BEATS - 1);
    mem_req_o.aw.size  = 3'd3;
    mem_req_o.aw.burst = BURST_INCR;
    mem_req_o.w_valid  = w_valid;
    mem_req_o.w.data   = data[64*beat_cnt +: 64];
    mem_req_o.w.strb   = '1;
    mem_req_o.w.last   = (beat_cnt == LAST_BEAT);
    mem_req_o.b_ready  = b_ready;
  end

  assign req_ready_o = req_ready;
  assign done_o      = done;
  assign error_o     = error;

  logic unused_inputs;
  assign unused_inputs = ^{req_addr_i[2:0], mem_resp_i.ar_ready, mem_resp_i.r_valid,
                           mem_resp_i.r, mem_resp_i.b.id};

endmodule

`default_nettype wire

// File: tb/tb_rv_iommu_rec_wr.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_rv_iommu_rec_wr                                               |
// | Brief   : Directed self-checking bench for rv_iommu_rec_wr with a small    |
// |           reactive AXI slave. Timeout scenario needs                       |
// |           RV_IOMMU_REC_WR_TIMEOUT_EN.                                      |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rv_iommu_rec_wr;
  import axi_pkg::*;

  localparam int unsigned N_BEATS = 4;
  localparam int unsigned TO_CYC  = 16;

  logic                  clk;
  logic                  rst_n;
  logic                  req_valid;
  logic                  req_ready;
  logic [63:0]           req_addr;
  logic [64*N_BEATS-1:0] req_data;
  logic                  done;
  logic                  error;
  logic                  timeout;
  req_t                  mem_req;
  resp_t                 mem_resp;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // slave knobs
  int         aw_stall   = 0;
  bit         w_toggle   = 0;
  int         b_delay    = 0;
  logic [1:0] b_resp_sel = RESP_OKAY;

  // slave state and observations
  bit          w_phase, b_pending, aw_done, aw_hold, w_hold, prev_ready;
  int          b_wait;
  aw_chan_t    aw_held, aw_rec;
  w_chan_t     w_held;
  logic [63:0] beat_q[$];
  bit          last_q[$];
  int          n_done = 0;
  int          done_cyc, last_w_cyc, b_hs_cyc, rise_cyc;
  bit          done_err, done_to;

  rv_iommu_rec_wr #(
    .axi_req_t      (req_t),
    .axi_rsp_t      (resp_t),
    .AXI_ID         (rv_iommu_pkg::AXI_ID_FQ),
    .N_BEATS        (N_BEATS),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .done_o      (done),
    .error_o     (error),
    .timeout_o   (timeout),
    .mem_req_o   (mem_req),
    .mem_resp_i  (mem_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reactive slave and protocol monitor, evaluated once per cycle at the falling edge
  initial begin
    mem_resp = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_resp   = '0;
        b_pending  = 0;
        b_wait     = 0;
        aw_done    = 0;
        aw_hold    = 0;
        w_hold     = 0;
        w_phase    = 0;
        prev_ready = 0;
      end else begin
        check("aw_w_overlap", 64'(mem_req.aw_valid & mem_req.w_valid), 64'd0);
        check("w_before_aw", 64'(mem_req.w_valid & ~aw_done), 64'd0);
        check("ar_r_tied", 64'(mem_req.ar_valid | mem_req.r_ready), 64'd0);
        if (aw_hold) begin
          check("aw_valid_dropped", 64'(mem_req.aw_valid), 64'd1);
          check("aw_stable", 64'(mem_req.aw == aw_held), 64'd1);
        end
        if (w_hold) begin
          check("w_valid_dropped", 64'(mem_req.w_valid), 64'd1);
          check("w_data_stable", mem_req.w.data, w_held.data);
          check("w_last_stable", 64'(mem_req.w.last), 64'(w_held.last));
        end
        if (mem_req.aw_valid && aw_stall > 0) begin
          mem_resp.aw_ready = 1'b0;
          aw_stall--;
        end else begin
          mem_resp.aw_ready = mem_req.aw_valid;
        end
        w_phase = ~w_phase;
        mem_resp.w_ready = mem_req.w_valid && (!w_toggle || w_phase);
        if (b_pending && b_wait > 0) b_wait--;
        mem_resp.b_valid = b_pending && (b_wait == 0);
        mem_resp.b.resp  = b_pending ? b_resp_sel : RESP_OKAY;
        mem_resp.b.id    = 4'd1;

        aw_hold = mem_req.aw_valid && !mem_resp.aw_ready;
        aw_held = mem_req.aw;
        if (mem_req.aw_valid && mem_resp.aw_ready) begin
          aw_rec  = mem_req.aw;
          aw_done = 1;
        end
        w_hold = mem_req.w_valid && !mem_resp.w_ready;
        w_held = mem_req.w;
        if (mem_req.w_valid && mem_resp.w_ready) begin
          beat_q.push_back(mem_req.w.data);
          last_q.push_back(mem_req.w.last);
          if (mem_req.w.last) begin
            b_pending  = 1;
            b_wait     = b_delay;
            last_w_cyc = cyc;
          end
        end
        if (mem_resp.b_valid && mem_req.b_ready) begin
          b_pending = 0;
          aw_done   = 0;
          b_hs_cyc  = cyc;
        end
        if (done) begin
          n_done++;
          done_cyc = cyc;
          done_err = error;
          done_to  = timeout;
        end
        if (req_ready && !prev_ready) rise_cyc = cyc;
        prev_ready = req_ready;
      end
    end
  end

  task automatic send_req(input logic [63:0] addr, input logic [64*N_BEATS-1:0] data,
                          output int hs);
    bit got;
    got = 0;
    hs  = -1;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = addr;
    req_data  = data;
    for (int i = 0; i < 200 && !got; i++) begin
      if (req_ready) begin
        got = 1;
        hs  = cyc;
      end else begin
        @(negedge clk);
      end
    end
    check("req_accept", 64'(got), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int start, input int budget);
    for (int i = 0; i < budget && n_done <= start; i++) @(posedge clk);
    check("done_seen", 64'(n_done > start), 64'd1);
  endtask

  task automatic check_beats(input string tag, input logic [64*N_BEATS-1:0] data);
    logic [64*N_BEATS-1:0] d;
    d = data;
    check({tag, "_beat_count"}, 64'(beat_q.size()), 64'(N_BEATS));
    for (int i = 0; i < N_BEATS; i++) begin
      if (i < beat_q.size()) begin
        check({tag, "_beat_data"}, beat_q[i], d[64*i +: 64]);
        check({tag, "_beat_last"}, 64'(last_q[i]), 64'(i == N_BEATS - 1));
      end
    end
  endtask

  initial begin
    int hs, hs2, start;
    logic [64*N_BEATS-1:0] d;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_aw_valid", 64'(mem_req.aw_valid), 64'd0);
    check("rst_w_valid", 64'(mem_req.w_valid), 64'd0);
    check("rst_b_ready", 64'(mem_req.b_ready), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    // T1: slave always ready, unaligned address, beats 0x11..0x44
    d = {64'h44, 64'h33, 64'h22, 64'h11};
    beat_q.delete(); last_q.delete(); start = n_done;
    send_req(64'h0000_0000_8000_1007, d, hs);
    wait_done(start, 100);
    @(posedge clk);
    check("t1_aw_addr", aw_rec.addr, 64'h0000_0000_8000_1000);
    check("t1_aw_len", 64'(aw_rec.len), 64'd3);
    check("t1_aw_size", 64'(aw_rec.size), 64'd3);
    check("t1_aw_burst", 64'(aw_rec.burst), 64'd1);
    check("t1_aw_id", 64'(aw_rec.id), 64'd1);
    check("t1_aw_misc", 64'({aw_rec.lock, aw_rec.cache, aw_rec.prot, aw_rec.qos}), 64'd0);
    check("t1_ar_zero", 64'(mem_req.ar == ar_chan_t'(0)), 64'd1);
    check_beats("t1", d);
    check("t1_latency", 64'(done_cyc - hs), 64'd7);
    check("t1_error", 64'(done_err), 64'd0);
    check("t1_timeout", 64'(done_to), 64'd0);
    check("t1_ready_rise", 64'(rise_cyc - done_cyc), 64'd0);

    // T2: AW stalled 5 cycles, W ready every other cycle
    d = {64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003,
         64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
    beat_q.delete(); last_q.delete(); start = n_done;
    aw_stall = 5; w_toggle = 1;
    send_req(64'h1234_5678_9ABC_DEF0, d, hs);
    wait_done(start, 200);
    repeat (10) @(posedge clk);
    w_toggle = 0;
    check("t2_aw_stall_used", 64'(aw_stall), 64'd0);
    check("t2_aw_addr", aw_rec.addr, 64'h1234_5678_9ABC_DEF0);
    check_beats("t2", d);
    check("t2_one_done", 64'(n_done - start), 64'd1);
    check("t2_error", 64'(done_err), 64'd0);

    // T3: SLVERR, then a request waiting on req_ready is taken the cycle it rises
    b_resp_sel = RESP_SLVERR;
    beat_q.delete(); last_q.delete(); start = n_done;
    send_req(64'h0000_0000_4000_0040, d, hs);
    send_req(64'h0000_0000_4000_0080, {64'h8, 64'h7, 64'h6, 64'h5}, hs2);
    @(posedge clk);
    b_resp_sel = RESP_OKAY;
    check("t3_done_count", 64'(n_done - start), 64'd1);
    check("t3_error", 64'(done_err), 64'd1);
    check("t3_timeout", 64'(done_to), 64'd0);
    check("t3_latency", 64'(done_cyc - hs), 64'd7);
    check("t3_b2b_accept", 64'(hs2 - done_cyc), 64'd0);
    wait_done(start + 1, 100);
    @(posedge clk);
    check("t3_second_error", 64'(done_err), 64'd0);
    check("t3_second_latency", 64'(done_cyc - hs2), 64'd7);
    check("t3_second_addr", aw_rec.addr, 64'h0000_0000_4000_0080);

`ifdef RV_IOMMU_REC_WR_TIMEOUT_EN
    // T4: B withheld beyond the limit, late B absorbed in DRAIN
    b_delay = 40;
    start = n_done;
    send_req(64'h0000_0000_5000_0000, d, hs);
    wait_done(start, 100);
    @(posedge clk);
    check("t4_timeout", 64'(done_to), 64'd1);
    check("t4_error", 64'(done_err), 64'd1);
    check("t4_timeout_at", 64'(done_cyc - last_w_cyc), 64'(TO_CYC + 1));
    check("t4_ready_low", 64'(req_ready), 64'd0);
    for (int i = 0; i < 100 && !req_ready; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    b_delay = 0;
    check("t4_late_b", 64'(b_hs_cyc - last_w_cyc), 64'd40);
    check("t4_ready_after_b", 64'(rise_cyc - b_hs_cyc), 64'd1);
    check("t4_one_done", 64'(n_done - start), 64'd1);
`endif

    // T5: reset during the second beat, then a clean transaction
    beat_q.delete(); last_q.delete(); start = n_done;
    send_req(64'h0000_0000_6000_0000, d, hs);
    for (int i = 0; i < 50 && beat_q.size() < 1; i++) @(posedge clk);
    check("t5_beat1_seen", 64'(beat_q.size()), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_aw_valid", 64'(mem_req.aw_valid), 64'd0);
    check("t5_rst_w_valid", 64'(mem_req.w_valid), 64'd0);
    check("t5_rst_b_ready", 64'(mem_req.b_ready), 64'd0);
    check("t5_rst_req_ready", 64'(req_ready), 64'd1);
    check("t5_rst_done", 64'(done), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    check("t5_no_done", 64'(n_done - start), 64'd0);
    d = {64'h0F0F, 64'h0E0E, 64'h0D0D, 64'h0C0C};
    beat_q.delete(); last_q.delete(); start = n_done;
    send_req(64'h0000_0000_6000_0100, d, hs);
    wait_done(start, 100);
    @(posedge clk);
    check_beats("t5", d);
    check("t5_latency", 64'(done_cyc - hs), 64'd7);
    check("t5_error", 64'(done_err), 64'd0);
    check("t5_addr", aw_rec.addr, 64'h0000_0000_6000_0100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (checks %0d)", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/rv_iommu_rec_wr.md
# rv_iommu_rec_wr

Single-outstanding AXI write master that commits one fixed-size in-memory record (default 32-byte fault-queue record) as a single INCR burst. It sits directly upstream of the data-structures interface wrapper and drives one of its AW/W/B requestor ports (FQ, CQ or MSI IG), using a fixed AXI ID so B responses route back to it. It guarantees the ordering that wrapper relies on: W beats only after the AW handshake, and exactly one transaction in flight.

## Interface
- axi_req_t, logic: AXI full request struct, same type as the wrapper's requestor ports
- axi_rsp_t, logic: AXI full response struct
- AXI_ID, 0: AWID driven on every transaction (0 = CQ, 1 = FQ, 2 = MSI IG slot)
- N_BEATS, 4: 64-bit beats per record, legal 1..8
- TIMEOUT_CYCLES, 1024: B-wait limit; used only when the timeout feature is compiled in
---
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  record write request
- req_ready_o  out  1  request accepted when high with req_valid_i
- req_addr_i  in  64  record base physical address, 8-byte aligned
- req_data_i  in  64*N_BEATS  record payload, beat k = bits [64k+63:64k]
- done_o  out  1  one-cycle pulse: transaction finished
- error_o  out  1  qualifies done_o: BRESP != OKAY or timeout
- timeout_o  out  1  qualifies done_o: B-wait timeout (tied 0 without the macro)
- mem_req_o  out  axi_req_t  AXI request to the data-structures interface
- mem_resp_i  in  axi_rsp_t  AXI response from the data-structures interface

## Operation
- FSM states: IDLE, AW, W, B, DRAIN (DRAIN exists only with the macro).
- IDLE: req_ready_o=1. On req_valid_i&req_ready_o, capture addr (bits[2:0] forced 0) and data, then go to AW.
- AW: aw_valid=1; aw.id=AXI_ID, aw.addr=captured, aw.len=N_BEATS-1, aw.size=3, aw.burst=INCR, other fields 0. Hold all fields stable until aw_ready; then go to W with beat counter=0.
- W: w_valid=1, w.data=beat[cnt], w.strb all ones, w.last=(cnt==N_BEATS-1). On w_ready, increment cnt. On the last beat's handshake, go to B.
- B: b_ready=1. On b_valid, pulse done_o; set error_o=(b.resp!=OKAY); go to IDLE.
- ar_valid and r_ready are tied 0; AR fields are 0.
- aw_valid and w_valid are never high in the same cycle. w_valid is never high before the AW handshake.
- Reset mid-operation: all outputs return to their reset values immediately. No done_o is generated for the aborted transaction.

## Timing
- Reset values: req_ready_o=1 (IDLE); done_o, error_o, timeout_o, aw_valid, w_valid and b_ready are all 0.
- Minimum latency from request handshake to done_o, with slave always ready and B returned the cycle after w.last: N_BEATS+3 cycles.
  - 1 cycle AW, N_BEATS cycles W, then B.
- done_o is registered. It is high exactly one cycle after the B handshake cycle, and req_ready_o returns high in that same cycle.
- Valid signals never drop before their handshake. Back-pressure of any length is legal on AW, W and B.
- The beat counter has width max(1,$clog2(N_BEATS)) and never wraps past N_BEATS-1.

## Configuration
- Macro: RV_IOMMU_REC_WR_TIMEOUT_EN.
- Defined:
  - A counter runs in B; it is reset on entry to B.
  - When the counter reaches TIMEOUT_CYCLES without b_valid: pulse done_o with error_o=1 and timeout_o=1, then enter DRAIN.
  - DRAIN: b_ready=1 and req_ready_o=0. The late B is absorbed with no second done_o, then the FSM goes to IDLE.
  - A B arriving in the same cycle the limit is reached counts as a normal completion (no timeout).
- Undefined: B waits indefinitely, there is no counter or DRAIN state, and timeout_o is tied 0.

## Structure
- AXI burst/size/resp encodings come from the existing axi_pkg.
- rv_iommu_pkg holds the per-port AXI ID constants (CQ=0, FQ=1, MSI_IG=2, MRIF=3), shared with the wrapper's W/B select decode.
- The FSM state enum is local to the module.
- No sub-module: the beat counter and timeout counter are inline.

## Test plan
- Slave always ready, addr 0x8000_1007, data beats 0x11..0x44 -> AW addr 0x8000_1000, len 3, size 3, id AXI_ID; W beats 0x11, 0x22, 0x33, 0x44 with last on the 4th; done_o 7 cycles after the request; error_o=0.
- aw_ready held low 5 cycles, w_ready toggling every other cycle -> AW/W fields stable while stalled, no overlap of aw_valid and w_valid, beat order preserved, one done_o pulse.
- BRESP=SLVERR -> done_o=1 with error_o=1, timeout_o=0; the next request is accepted the same cycle req_ready_o rises.
- Macro on, TIMEOUT_CYCLES=16, B withheld 40 cycles -> done_o with error_o=1 and timeout_o=1 after 16 B-cycles; req_ready_o stays 0 until the late B handshake; no second done_o.
- rst_ni asserted during beat 2 -> all valids 0 and req_ready_o=1 immediately; a fresh request after release completes normally.
